imem_arb: RTL and testbench

IMEM_ARB -- requirements
Module: imem_arb

---
 rtl/imem_arb.sv | 130 +++++++++++++
 tb/tb_imem_arb.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imem_arb : instruction-memory arbiter between fetch stage and prog port    |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
module imem_arb #(
    parameter int MEM_SIZE        = 2048,
    parameter int AW              = 11,
    parameter int FETCH_BURST_MAX = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_boot_done,
    input  logic          i_fetch_req,
    input  logic [31:0]   i_fetch_addr,
    output logic          o_fetch_gnt,
    output logic          o_fetch_rvalid,
    output logic [31:0]   o_fetch_rdata,
    output logic          o_fetch_err,
    input  logic          i_prog_req,
    input  logic          i_prog_we,
    input  logic [31:0]   i_prog_addr,
    input  logic [31:0]   i_prog_wdata,
    output logic          o_prog_gnt,
    output logic          o_prog_rvalid,
    output logic [31:0]   o_prog_rdata,
    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [31:0]   o_mem_wdata,
    input  logic [31:0]   i_mem_rdata,
    output logic          o_boot
);

    localparam int          BW            = $clog2(FETCH_BURST_MAX + 1);
    localparam logic [BW-1:0] C_BURST_MAX = BW'(FETCH_BURST_MAX);
    localparam logic [29:0] C_MEM_WORDS   = 30'(MEM_SIZE);

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          fetch_pend_q, fetch_pend_d;
    logic          prog_pend_q, prog_pend_d;
    logic          rd_q, rd_d;
    logic          err_q, err_d;

    logic w_fetch_ok, w_prog_ok;
    logic w_fetch_gnt, w_prog_gnt;
    logic unused_addr_lsbs;

    assign w_fetch_ok       = i_fetch_addr[31:2] < C_MEM_WORDS;
    assign w_prog_ok        = i_prog_addr[31:2] < C_MEM_WORDS;
    assign unused_addr_lsbs = ^{i_fetch_addr[1:0], i_prog_addr[1:0]};

    // Fetch wins unless a waiting prog request has already seen a full burst.
    always_comb begin
        w_fetch_gnt = 1'b0;
        w_prog_gnt  = 1'b0;
        if (i_rst_n) begin
            if (state_q == ST_BOOT) begin
                w_prog_gnt = i_prog_req;
            end else if (i_fetch_req && !(i_prog_req && burst_q == C_BURST_MAX)) begin
                w_fetch_gnt = 1'b1;
            end else begin
                w_prog_gnt = i_prog_req;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_BOOT && i_boot_done) begin
            state_d = ST_RUN;
        end

        burst_d = burst_q;
        if (w_prog_gnt || !i_prog_req) begin
            burst_d = '0;
        end else if (w_fetch_gnt && burst_q != C_BURST_MAX) begin
            burst_d = burst_q + 1'b1;
        end

        fetch_pend_d = w_fetch_gnt;
        prog_pend_d  = w_prog_gnt;
        rd_d         = (w_fetch_gnt && w_fetch_ok) || (w_prog_gnt && w_prog_ok && !i_prog_we);
        err_d        = w_fetch_gnt && !w_fetch_ok;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= ST_BOOT;
            burst_q      <= '0;
            fetch_pend_q <= 1'b0;
            prog_pend_q  <= 1'b0;
            rd_q         <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            burst_q      <= burst_d;
            fetch_pend_q <= fetch_pend_d;
            prog_pend_q  <= prog_pend_d;
            rd_q         <= rd_d;
            err_q        <= err_d;
        end
    end

    assign o_fetch_gnt = w_fetch_gnt;
    assign o_prog_gnt  = w_prog_gnt;

    // Out-of-range accesses are granted but never reach the memory.
    assign o_mem_en    = (w_fetch_gnt && w_fetch_ok) || (w_prog_gnt && w_prog_ok);
    assign o_mem_we    = w_prog_gnt && w_prog_ok && i_prog_we;
    assign o_mem_addr  = w_prog_gnt ? i_prog_addr[AW+1:2] : i_fetch_addr[AW+1:2];
    assign o_mem_wdata = i_prog_wdata;

    // Strobes are masked while reset is held so an in-flight read is dropped.
    assign o_fetch_rvalid = fetch_pend_q && i_rst_n;
    assign o_fetch_err    = err_q && i_rst_n;
    assign o_fetch_rdata  = (fetch_pend_q && rd_q) ? i_mem_rdata : 32'h0;
    assign o_prog_rvalid  = prog_pend_q && i_rst_n;
    assign o_prog_rdata   = (prog_pend_q && rd_q) ? i_mem_rdata : 32'h0;

    assign o_boot = (state_q == ST_BOOT);

endmodule
`default_nettype wire

// File: tb/tb_imem_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_imem_arb : scoreboard testbench for imem_arb                            |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_imem_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        boot_done;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_gnt, fetch_rvalid, fetch_err;
    logic [31:0] fetch_rdata;
    logic        prog_req, prog_we;
    logic [31:0] prog_addr, prog_wdata;
    logic        prog_gnt, prog_rvalid;
    logic [31:0] prog_rdata;
    logic        mem_en, mem_we;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        boot;

    always #5 clk = ~clk;

    imem_arb #(.MEM_SIZE(2048), .AW(11), .FETCH_BURST_MAX(4)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_boot_done   (boot_done),
        .i_fetch_req   (fetch_req),
        .i_fetch_addr  (fetch_addr),
        .o_fetch_gnt   (fetch_gnt),
        .o_fetch_rvalid(fetch_rvalid),
        .o_fetch_rdata (fetch_rdata),
        .o_fetch_err   (fetch_err),
        .i_prog_req    (prog_req),
        .i_prog_we     (prog_we),
        .i_prog_addr   (prog_addr),
        .i_prog_wdata  (prog_wdata),
        .o_prog_gnt    (prog_gnt),
        .o_prog_rvalid (prog_rvalid),
        .o_prog_rdata  (prog_rdata),
        .o_mem_en      (mem_en),
        .o_mem_we      (mem_we),
        .o_mem_addr    (mem_addr),
        .o_mem_wdata   (mem_wdata),
        .i_mem_rdata   (mem_rdata),
        .o_boot        (boot)
    );

    // Synchronous-read instruction memory
    logic [31:0] sram [0:2047];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata      <= sram[mem_addr];
        end
    end

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    exp_t fq[$];
    exp_t pq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops the expected response whenever a port presents one
    always @(negedge clk) begin
        exp_t e;
        if (fetch_rvalid) begin
            if (fq.size() == 0) begin
                chk("fetch_unexpected_rvalid", 32'(fetch_rvalid), 32'h0);
            end else begin
                e = fq.pop_front();
                chk("fetch_rdata", fetch_rdata, e.data);
                chk("fetch_err", 32'(fetch_err), 32'(e.err));
                chk("fetch_latency", 32'(cyc), 32'(e.due));
            end
        end else if (fq.size() != 0 && fq[0].due <= cyc) begin
            e = fq.pop_front();
            chk("fetch_missing_rvalid", 32'(fetch_rvalid), 32'h1);
        end
        if (prog_rvalid) begin
            if (pq.size() == 0) begin
                chk("prog_unexpected_rvalid", 32'(prog_rvalid), 32'h0);
            end else begin
                e = pq.pop_front();
                chk("prog_rdata", prog_rdata, e.data);
                chk("prog_latency", 32'(cyc), 32'(e.due));
            end
        end else if (pq.size() != 0 && pq[0].due <= cyc) begin
            e = pq.pop_front();
            chk("prog_missing_rvalid", 32'(prog_rvalid), 32'h1);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        fetch_req = 1'b0;
        prog_req  = 1'b0;
        boot_done = 1'b0;
        repeat (n) next_cycle();
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] d, input logic oor);
        exp_t e;
        fetch_req  = 1'b1;
        fetch_addr = a;
        prog_req   = 1'b0;
        @(negedge clk);
        chk("fetch_gnt", 32'(fetch_gnt), 32'h1);
        chk("fetch_mem_en", 32'(mem_en), 32'(!oor));
        if (!oor) chk("fetch_mem_addr", 32'(mem_addr), 32'(a[12:2]));
        if (fetch_gnt) begin
            e.data = d; e.err = oor; e.due = cyc + 1;
            fq.push_back(e);
        end
        next_cycle();
    endtask

    task automatic prog(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] d, input logic en, input logic done);
        exp_t e;
        prog_req   = 1'b1;
        prog_we    = we;
        prog_addr  = a;
        prog_wdata = wd;
        boot_done  = done;
        fetch_req  = 1'b0;
        @(negedge clk);
        chk("prog_gnt", 32'(prog_gnt), 32'h1);
        chk("prog_mem_en", 32'(mem_en), 32'(en));
        chk("prog_mem_we", 32'(mem_we), 32'(en & we));
        if (prog_gnt) begin
            e.data = d; e.err = 1'b0; e.due = cyc + 1;
            pq.push_back(e);
        end
        next_cycle();
        boot_done = 1'b0;
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0; boot_done = 1'b0;
        fetch_req = 1'b1; fetch_addr = 32'h4;
        prog_req = 1'b1; prog_we = 1'b0; prog_addr = 32'h0; prog_wdata = 32'h0;
        repeat (2) next_cycle();
        @(negedge clk);
        chk("rst_fetch_gnt", 32'(fetch_gnt), 32'h0);
        chk("rst_prog_gnt", 32'(prog_gnt), 32'h0);
        chk("rst_mem_en", 32'(mem_en), 32'h0);
        chk("rst_boot", 32'(boot), 32'h1);
        chk("rst_rvalid", 32'({fetch_rvalid, prog_rvalid, fetch_err}), 32'h0);
        next_cycle();
        rst_n = 1'b1;
        prog_req = 1'b0;

        // Fetch is locked out while booting
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("boot_fetch_gnt", 32'(fetch_gnt), 32'h0);
            chk("boot_flag", 32'(boot), 32'h1);
            next_cycle();
        end

        // Boot load; the OOR write must not alias onto word 0
        prog(1'b1, 32'h0000_0000, 32'h0000_0013, 32'h0, 1'b1, 1'b0);
        prog(1'b1, 32'h0000_0004, 32'h0000_0013, 32'h0, 1'b1, 1'b0);
        prog(1'b1, 32'h0000_0008, 32'h1111_1111, 32'h0, 1'b1, 1'b0);
        prog(1'b1, 32'h0000_000C, 32'h2222_2222, 32'h0, 1'b1, 1'b0);
        prog(1'b1, 32'h0000_2000, 32'h0000_0BAD, 32'h0, 1'b0, 1'b0);
        prog(1'b1, 32'h0000_1FFC, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b1);
        idle(1);
        chk("run_boot_flag", 32'(boot), 32'h0);

        fetch(32'h0000_0004, 32'h0000_0013, 1'b0);
        idle(2);

        // Back-to-back stream; low address bits are ignored
        fetch(32'h0000_0000, 32'h0000_0013, 1'b0);
        fetch(32'h0000_0004, 32'h0000_0013, 1'b0);
        fetch(32'h0000_000A, 32'h1111_1111, 1'b0);
        fetch(32'h0000_000F, 32'h2222_2222, 1'b0);
        fetch(32'h0000_1FFC, 32'hDEAD_BEEF, 1'b0);
        fetch(32'h0000_2000, 32'h0000_0000, 1'b1);
        fetch(32'hFFFF_FFFC, 32'h0000_0000, 1'b1);
        idle(2);

        prog(1'b0, 32'h0000_000C, 32'h0, 32'h2222_2222, 1'b1, 1'b0);
        prog(1'b0, 32'h0000_2000, 32'h0, 32'h0000_0000, 1'b0, 1'b0);
        idle(2);

        // Both requesters saturated: four fetches then one prog, repeating
        fetch_req = 1'b1; fetch_addr = 32'h8;
        prog_req = 1'b1; prog_we = 1'b0; prog_addr = 32'hC;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            chk("fair_fetch_gnt", 32'(fetch_gnt), 32'((k % 5) != 4));
            chk("fair_prog_gnt", 32'(prog_gnt), 32'((k % 5) == 4));
            if (fetch_gnt) begin
                e.data = 32'h1111_1111; e.err = 1'b0; e.due = cyc + 1;
                fq.push_back(e);
            end
            if (prog_gnt) begin
                e.data = 32'h2222_2222; e.err = 1'b0; e.due = cyc + 1;
                pq.push_back(e);
            end
            next_cycle();
        end
        idle(2);

        // Reset the cycle after a fetch grant: the response is dropped
        fetch_req = 1'b1; fetch_addr = 32'h4;
        @(negedge clk);
        chk("rstmid_fetch_gnt", 32'(fetch_gnt), 32'h1);
        next_cycle();
        rst_n = 1'b0; fetch_req = 1'b0;
        @(negedge clk);
        chk("rstmid_rvalid", 32'(fetch_rvalid), 32'h0);
        next_cycle();
        @(negedge clk);
        chk("rstmid_boot", 32'(boot), 32'h1);
        chk("rstmid_rvalid2", 32'(fetch_rvalid), 32'h0);
        next_cycle();
        rst_n = 1'b1;
        idle(3);

        chk("fetch_queue_drained", 32'(fq.size()), 32'h0);
        chk("prog_queue_drained", 32'(pq.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
